pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register that replaces the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the SIMD AES pipeline.
- Carries a data bundle and a control bundle from stage N to stage N+1.
- Uses a valid/ready handshake with stall back-pressure, synchronous flush and bubble insertion.
- SKID=1 adds a second entry, which breaks the combinational ready path.
- Control bits are forced to 0 whenever the stage holds no valid entry, so bubbles never write the register files.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the SIMD AES pipeline stage registers: bundle geometry,
// control-bundle layout and the occupancy state encoding.
package pipe_pkg;

  localparam int LANE_W = 32;
  localparam int NLANES = 4;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic       reg_write;
    logic       vreg_write;
    logic       colwrite;
    logic [1:0] mem_to_reg;
    logic [1:0] columna;
  } ctrl_t;

  // Encoding doubles as the entry count, so level can be read straight off the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the stage performance counters.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (clr)
      value_q <= '0;
    else if (inc && (value_q != {CNT_W{1'b1}}))
      value_q <= value_q + 1'b1;
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake, flush, optional skid entry,
// control bundle zeroed whenever no entry is presented.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = NLANES*LANE_W + RD_W,
  parameter int CTRL_W = $bits(ctrl_t),
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              main_valid, skid_valid;
  logic              accept, consume;
  logic              ld_main_in, ld_main_skid, ld_skid;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // With a skid entry, ready comes only from the registered state, never from out_ready.
  assign in_ready = (SKID != 0) ? (~skid_valid & ~flush & ~rst)
                                : (~flush & ~rst & (out_ready | ~main_valid));

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d    = BUSY;
        ld_main_in = 1'b1;
      end
      BUSY: begin
        if (accept && consume) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: if (consume) begin
        state_d      = BUSY;
        ld_main_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (ld_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (ld_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;
  assign level     = state_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (main_valid & ~out_ready),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid and non-skid instances plus a narrow-counter one.
module tb_pipe_stage_reg;

  localparam int DW = 133;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // SKID=1, CNT_W=16
  logic          s1_flush, s1_iv, s1_ir, s1_ov, s1_or;
  logic [DW-1:0] s1_id, s1_od;
  logic [CW-1:0] s1_ic, s1_oc;
  logic [1:0]    s1_lvl;
  logic [15:0]   s1_sc;
  // SKID=0, CNT_W=16
  logic          s0_flush, s0_iv, s0_ir, s0_ov, s0_or;
  logic [DW-1:0] s0_id, s0_od;
  logic [CW-1:0] s0_ic, s0_oc;
  logic [1:0]    s0_lvl;
  logic [15:0]   s0_sc;
  // SKID=1, CNT_W=4
  logic          c4_flush, c4_iv, c4_ir, c4_ov, c4_or;
  logic [DW-1:0] c4_id, c4_od;
  logic [CW-1:0] c4_ic, c4_oc;
  logic [1:0]    c4_lvl;
  logic [3:0]    c4_sc;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .flush(s1_flush), .in_valid(s1_iv), .in_ready(s1_ir),
    .in_data(s1_id), .in_ctrl(s1_ic), .out_valid(s1_ov), .out_ready(s1_or),
    .out_data(s1_od), .out_ctrl(s1_oc), .level(s1_lvl), .stall_cnt(s1_sc));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .flush(s0_flush), .in_valid(s0_iv), .in_ready(s0_ir),
    .in_data(s0_id), .in_ctrl(s0_ic), .out_valid(s0_ov), .out_ready(s0_or),
    .out_data(s0_od), .out_ctrl(s0_oc), .level(s0_lvl), .stall_cnt(s0_sc));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .flush(c4_flush), .in_valid(c4_iv), .in_ready(c4_ir),
    .in_data(c4_id), .in_ctrl(c4_ic), .out_valid(c4_ov), .out_ready(c4_or),
    .out_data(c4_od), .out_ctrl(c4_oc), .level(c4_lvl), .stall_cnt(c4_sc));

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s1_flush = 0; s1_iv = 1; s1_id = 5; s1_ic = 7'h7F; s1_or = 0;
    s0_flush = 0; s0_iv = 0; s0_id = 0; s0_ic = 0;     s0_or = 0;
    c4_flush = 0; c4_iv = 0; c4_id = 0; c4_ic = 0;     c4_or = 0;

    // 1: reset
    tick(); tick();
    chk("rst_out_valid", s1_ov, 0);
    chk("rst_out_ctrl", s1_oc, 0);
    chk("rst_level", s1_lvl, 0);
    chk("rst_in_ready", s1_ir, 0);
    chk("rst_out_data", s1_od, 0);
    chk("rst_stall", s1_sc, 0);
    rst = 0; s1_iv = 0;
    #1 chk("rel_in_ready", s1_ir, 1);

    // 2: streaming with out_ready=1
    s1_iv = 1; s1_id = 1; s1_ic = 7'h7F; s1_or = 1;
    tick();
    chk("str_d1", s1_od, 1);
    chk("str_c1", s1_oc, 7'h7F);
    chk("str_lvl1", s1_lvl, 1);
    s1_id = 2;
    tick();
    chk("str_d2", s1_od, 2);
    s1_id = 3;
    tick();
    chk("str_d3", s1_od, 3);
    chk("str_lvl3", s1_lvl, 1);
    s1_iv = 0;
    tick();
    chk("str_drain_lvl", s1_lvl, 0);
    chk("str_drain_ov", s1_ov, 0);
    chk("str_drain_ctrl", s1_oc, 0);
    chk("str_stall", s1_sc, 0);

    // 3: back-pressure into the skid entry
    s1_or = 0; s1_iv = 1; s1_id = 'hA; s1_ic = 7'h15;
    tick();
    chk("bp_A_data", s1_od, 'hA);
    chk("bp_A_ready", s1_ir, 1);
    s1_id = 'hB; s1_ic = 7'h2A;
    tick();
    chk("bp_full_lvl", s1_lvl, 2);
    chk("bp_full_ready", s1_ir, 0);
    chk("bp_stall1", s1_sc, 1);
    s1_id = 'hC; s1_ic = 7'h01;
    tick();
    chk("bp_hold_data", s1_od, 'hA);
    chk("bp_hold_lvl", s1_lvl, 2);
    tick();
    chk("bp_stall3", s1_sc, 3);
    s1_or = 1;
    #1 chk("bp_ready_not_comb", s1_ir, 0);
    tick();
    chk("bp_B_data", s1_od, 'hB);
    chk("bp_B_ctrl", s1_oc, 7'h2A);
    chk("bp_B_lvl", s1_lvl, 1);
    tick();
    chk("bp_C_data", s1_od, 'hC);
    chk("bp_C_lvl", s1_lvl, 1);
    s1_iv = 0;
    tick();
    chk("bp_end_lvl", s1_lvl, 0);
    chk("bp_end_stall", s1_sc, 3);

    // 4: flush from FULL
    s1_or = 0; s1_iv = 1; s1_id = 'h11; s1_ic = 7'h33;
    tick();
    s1_id = 'h22;
    tick();
    chk("fl_pre_lvl", s1_lvl, 2);
    chk("fl_pre_stall", s1_sc, 4);
    s1_flush = 1; s1_id = 'h33;
    #1;
    chk("fl_in_ready", s1_ir, 0);
    chk("fl_out_hold", s1_od, 'h11);
    tick();
    chk("fl_lvl", s1_lvl, 0);
    chk("fl_ov", s1_ov, 0);
    chk("fl_ctrl", s1_oc, 0);
    chk("fl_stall", s1_sc, 5);
    chk("fl_data_kept", s1_od, 'h11);
    s1_flush = 0; s1_iv = 0;
    tick();
    chk("fl_not_accepted", s1_lvl, 0);

    // 5: SKID=0 ready follows out_ready
    s0_iv = 1; s0_id = 'h50; s0_ic = 7'h05; s0_or = 0;
    #1 chk("s0_empty_ready", s0_ir, 1);
    tick();
    chk("s0_d50", s0_od, 'h50);
    chk("s0_ov", s0_ov, 1);
    s0_or = 1; s0_id = 'h51;
    #1 chk("s0_ready1", s0_ir, 1);
    tick();
    chk("s0_d51", s0_od, 'h51);
    s0_or = 0; s0_id = 'h52;
    #1 chk("s0_ready0", s0_ir, 0);
    tick();
    chk("s0_d51_hold", s0_od, 'h51);
    s0_or = 1;
    #1 chk("s0_ready1b", s0_ir, 1);
    tick();
    chk("s0_d52", s0_od, 'h52);
    s0_iv = 0;
    tick();
    chk("s0_drain_lvl", s0_lvl, 0);
    chk("s0_stall", s0_sc, 1);

    // 6: CNT_W=4 saturation
    c4_iv = 1; c4_id = 9; c4_ic = 7'h7F; c4_or = 0;
    tick();
    c4_iv = 0;
    repeat (14) tick();
    chk("c4_cnt14", c4_sc, 14);
    repeat (6) tick();
    chk("c4_sat", c4_sc, 15);
    chk("c4_lvl", c4_lvl, 1);
    rst = 1;
    tick();
    chk("c4_rst_cnt", c4_sc, 0);
    chk("c4_rst_lvl", c4_lvl, 0);
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
